// File: rtl/shim_spi_cs_timing_calc.sv
// rtl/shim_spi_cs_timing_calc.sv - SPI n_cs high-time calculator with two device timing profiles
module shim_spi_cs_timing_calc #(
  parameter int unsigned T_UPDATE_NS_0      = 830,
  parameter int unsigned T_MIN_CS_HIGH_NS_0 = 30,
  parameter int unsigned CMD_BITS_0         = 24,
  parameter int unsigned T_UPDATE_NS_1      = 1000,
  parameter int unsigned T_MIN_CS_HIGH_NS_1 = 30,
  parameter int unsigned CMD_BITS_1         = 16,
  parameter int unsigned MIN_CS_HIGH_CYCLES = 4,
  parameter int unsigned OUT_WIDTH          = 5
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [31:0]          spi_clk_freq_hz,
  input  logic                 profile_sel,
  input  logic                 calc,
  output logic [OUT_WIDTH-1:0] n_cs_high_time,
  output logic                 saturated,
  output logic                 done,
  output logic                 lock_viol
);

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    DIV_UPD  = 3'd1,
    DIV_HIGH = 3'd2,
    RESULT   = 3'd3,
    DONE     = 3'd4
  } state_t;

  localparam logic [31:0] T_UPD0   = 32'(T_UPDATE_NS_0);
  localparam logic [31:0] T_UPD1   = 32'(T_UPDATE_NS_1);
  localparam logic [31:0] T_MIN0   = 32'(T_MIN_CS_HIGH_NS_0);
  localparam logic [31:0] T_MIN1   = 32'(T_MIN_CS_HIGH_NS_1);
  localparam logic [31:0] CMD0     = 32'(CMD_BITS_0);
  localparam logic [31:0] CMD1     = 32'(CMD_BITS_1);
  localparam logic [31:0] MIN_HI   = 32'(MIN_CS_HIGH_CYCLES);
  localparam logic [31:0] SAT_VAL  = 32'((64'd1 << OUT_WIDTH) - 64'd1);
  localparam logic [32:0] DIVISOR  = 33'd1_000_000_000;
  localparam logic [63:0] ROUND_UP = 64'd999_999_999;
  localparam logic [5:0]  LAST_IT  = 6'd32;

  state_t                 state_q, state_d;
  logic                   calc_prev_q;
  logic [31:0]            freq_q, freq_d;
  logic                   prof_q, prof_d;
  logic [31:0]            rem_q, rem_d;
  logic [31:0]            lo_q, lo_d;
  logic [31:0]            quo_q, quo_d;
  logic [5:0]             cnt_q, cnt_d;
  logic [31:0]            upd_q, upd_d;
  logic [31:0]            hi_q, hi_d;
  logic [OUT_WIDTH-1:0]   ncs_q, ncs_d;
  logic                   sat_q, sat_d;
  logic                   done_q, done_d;
  logic                   viol_q, viol_d;

  logic [31:0] mul_t;
  logic [31:0] mul_f;
  logic [63:0] dividend;
  logic [32:0] trial;
  logic        trial_ge;
  logic [31:0] cmd_bits;
  logic [31:0] result_r;
  logic        mismatch;

  // Shared multiplier: start-of-request operands come from the live inputs,
  // the second division reuses the latched frequency and profile.
  always_comb begin
    mul_t = 32'd0;
    mul_f = 32'd0;
    if (state_q == IDLE) begin
      mul_t = profile_sel ? T_UPD1 : T_UPD0;
      mul_f = spi_clk_freq_hz;
    end else begin
      mul_t = prof_q ? T_MIN1 : T_MIN0;
      mul_f = freq_q;
    end
    dividend = ({32'd0, mul_t} * {32'd0, mul_f}) + ROUND_UP;
  end

  // One restoring step: next dividend bit enters the remainder before the compare.
  always_comb begin
    trial    = {rem_q, lo_q[31]};
    trial_ge = (trial >= DIVISOR);
    cmd_bits = prof_q ? CMD1 : CMD0;
    result_r = (upd_q > hi_q) ? upd_q : hi_q;
    mismatch = (spi_clk_freq_hz != freq_q) || (profile_sel != prof_q);
  end

  // Next-state and datapath control; aborts outrank normal sequencing.
  always_comb begin
    state_d = state_q;
    freq_d  = freq_q;
    prof_d  = prof_q;
    rem_d   = rem_q;
    lo_d    = lo_q;
    quo_d   = quo_q;
    cnt_d   = cnt_q;
    upd_d   = upd_q;
    hi_d    = hi_q;
    ncs_d   = ncs_q;
    sat_d   = sat_q;
    done_d  = done_q;
    viol_d  = viol_q;

    if (state_q != IDLE && mismatch) begin
      viol_d  = 1'b1;
      done_d  = 1'b0;
      state_d = IDLE;
    end else if (state_q != IDLE && !calc) begin
      done_d  = 1'b0;
      state_d = IDLE;
    end else begin
      case (state_q)
        IDLE: begin
          if (calc && !calc_prev_q) begin
            freq_d  = spi_clk_freq_hz;
            prof_d  = profile_sel;
            viol_d  = 1'b0;
            sat_d   = 1'b0;
            rem_d   = dividend[63:32];
            lo_d    = dividend[31:0];
            quo_d   = 32'd0;
            cnt_d   = 6'd0;
            state_d = DIV_UPD;
          end
        end
        DIV_UPD, DIV_HIGH: begin
          if (cnt_q != LAST_IT) begin
            rem_d = trial_ge ? 32'(trial - DIVISOR) : trial[31:0];
            quo_d = {quo_q[30:0], trial_ge};
            lo_d  = {lo_q[30:0], 1'b0};
            cnt_d = cnt_q + 6'd1;
          end else if (state_q == DIV_UPD) begin
            upd_d   = (quo_q > cmd_bits) ? (quo_q - cmd_bits) : 32'd0;
            rem_d   = dividend[63:32];
            lo_d    = dividend[31:0];
            quo_d   = 32'd0;
            cnt_d   = 6'd0;
            state_d = DIV_HIGH;
          end else begin
            hi_d    = (quo_q > MIN_HI) ? quo_q : MIN_HI;
            state_d = RESULT;
          end
        end
        RESULT: begin
          if (result_r > SAT_VAL) begin
            ncs_d = '1;
            sat_d = 1'b1;
          end else begin
            ncs_d = result_r[OUT_WIDTH-1:0];
            sat_d = 1'b0;
          end
          done_d  = 1'b1;
          state_d = DONE;
        end
        DONE: begin
          state_d = DONE;
        end
        default: begin
          state_d = IDLE;
        end
      endcase
    end
  end

  // State and datapath registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= IDLE;
      calc_prev_q <= 1'b0;
      freq_q      <= 32'd0;
      prof_q      <= 1'b0;
      rem_q       <= 32'd0;
      lo_q        <= 32'd0;
      quo_q       <= 32'd0;
      cnt_q       <= 6'd0;
      upd_q       <= 32'd0;
      hi_q        <= 32'd0;
      ncs_q       <= '0;
      sat_q       <= 1'b0;
      done_q      <= 1'b0;
      viol_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      calc_prev_q <= calc;
      freq_q      <= freq_d;
      prof_q      <= prof_d;
      rem_q       <= rem_d;
      lo_q        <= lo_d;
      quo_q       <= quo_d;
      cnt_q       <= cnt_d;
      upd_q       <= upd_d;
      hi_q        <= hi_d;
      ncs_q       <= ncs_d;
      sat_q       <= sat_d;
      done_q      <= done_d;
      viol_q      <= viol_d;
    end
  end

  assign n_cs_high_time = ncs_q;
  assign saturated      = sat_q;
  assign done           = done_q;
  assign lock_viol      = viol_q;

endmodule

// File: tb/tb_shim_spi_cs_timing_calc.sv
// tb/tb_shim_spi_cs_timing_calc.sv - directed self-checking bench for shim_spi_cs_timing_calc
module tb_shim_spi_cs_timing_calc;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] freq;
  logic        prof;
  logic        calc;
  logic [4:0]  ncs;
  logic        sat;
  logic        done;
  logic        viol;
  logic [5:0]  ncs6;
  logic        sat6;
  logic        done6;
  logic        viol6;

  int checks = 0;
  int errors = 0;
  logic [4:0] last_ncs;
  logic [5:0] last_ncs6;

  always #5 clk = ~clk;

  shim_spi_cs_timing_calc dut (
    .clk(clk), .reset(reset), .spi_clk_freq_hz(freq), .profile_sel(prof), .calc(calc),
    .n_cs_high_time(ncs), .saturated(sat), .done(done), .lock_viol(viol)
  );

  shim_spi_cs_timing_calc #(.OUT_WIDTH(6)) dut6 (
    .clk(clk), .reset(reset), .spi_clk_freq_hz(freq), .profile_sel(prof), .calc(calc),
    .n_cs_high_time(ncs6), .saturated(sat6), .done(done6), .lock_viol(viol6)
  );

  task automatic test_reset();
    reset = 1'b1; calc = 1'b0; freq = 32'd0; prof = 1'b0;
    repeat (3) @(negedge clk);
    checks++;
    if ({ncs, sat, done, viol} !== 8'd0) begin
      errors++;
      $display("FAIL reset_w5: ncs=%0d sat=%0b done=%0b viol=%0b expected all 0", ncs, sat, done, viol);
    end
    checks++;
    if ({ncs6, sat6, done6, viol6} !== 9'd0) begin
      errors++;
      $display("FAIL reset_w6: ncs=%0d sat=%0b done=%0b viol=%0b expected all 0", ncs6, sat6, done6, viol6);
    end
    reset = 1'b0;
    @(negedge clk);
  endtask

  // r is the hand-computed unsaturated result max(upd, hi).
  task automatic run_calc(input logic [31:0] f, input logic p, input int unsigned r, input string name);
    logic [4:0] e5;
    logic [5:0] e6;
    logic       s5;
    logic       s6;
    s5 = (r > 31);
    s6 = (r > 63);
    e5 = s5 ? 5'd31 : 5'(r);
    e6 = s6 ? 6'd63 : 6'(r);
    @(negedge clk);
    freq = f; prof = p; calc = 1'b1;
    repeat (67) @(negedge clk);
    checks++;
    if (done !== 1'b0) begin
      errors++;
      $display("FAIL %s_early: done=%0b expected 0 one cycle before latency", name, done);
    end
    @(negedge clk);
    checks++;
    if (done !== 1'b1 || ncs !== e5 || sat !== s5) begin
      errors++;
      $display("FAIL %s_w5: done=%0b ncs=%0d sat=%0b expected done=1 ncs=%0d sat=%0b", name, done, ncs, sat, e5, s5);
    end
    checks++;
    if (done6 !== 1'b1 || ncs6 !== e6 || sat6 !== s6) begin
      errors++;
      $display("FAIL %s_w6: done=%0b ncs=%0d sat=%0b expected done=1 ncs=%0d sat=%0b", name, done6, ncs6, sat6, e6, s6);
    end
    last_ncs = e5;
    last_ncs6 = e6;
    calc = 1'b0;
    @(negedge clk);
    checks++;
    if (done !== 1'b0) begin
      errors++;
      $display("FAIL %s_drop: done=%0b expected 0 after calc low", name, done);
    end
  endtask

  task automatic test_lock_freq();
    @(negedge clk);
    freq = 32'd50_000_000; prof = 1'b0; calc = 1'b1;
    repeat (20) @(negedge clk);
    freq = 32'd60_000_000;
    @(negedge clk);
    checks++;
    if (viol !== 1'b1 || done !== 1'b0 || ncs !== last_ncs) begin
      errors++;
      $display("FAIL lock_freq: viol=%0b done=%0b ncs=%0d expected viol=1 done=0 ncs=%0d", viol, done, ncs, last_ncs);
    end
    repeat (100) @(negedge clk);
    checks++;
    if (viol !== 1'b1 || done !== 1'b0) begin
      errors++;
      $display("FAIL lock_norestart: viol=%0b done=%0b expected viol=1 done=0", viol, done);
    end
    calc = 1'b0;
    @(negedge clk);
    calc = 1'b1;
    @(negedge clk);
    checks++;
    if (viol !== 1'b0) begin
      errors++;
      $display("FAIL lock_clear: viol=%0b expected 0", viol);
    end
    repeat (67) @(negedge clk);
    checks++;
    if (done !== 1'b1 || ncs !== 5'd26 || sat !== 1'b0) begin
      errors++;
      $display("FAIL lock_rerun: done=%0b ncs=%0d sat=%0b expected done=1 ncs=26 sat=0", done, ncs, sat);
    end
    last_ncs = 5'd26;
    calc = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_profile_toggle_done();
    @(negedge clk);
    freq = 32'd40_000_000; prof = 1'b1; calc = 1'b1;
    repeat (68) @(negedge clk);
    checks++;
    if (done !== 1'b1 || ncs !== 5'd24) begin
      errors++;
      $display("FAIL prof_done: done=%0b ncs=%0d expected done=1 ncs=24", done, ncs);
    end
    prof = 1'b0;
    @(negedge clk);
    checks++;
    if (viol !== 1'b1 || done !== 1'b0 || ncs !== 5'd24) begin
      errors++;
      $display("FAIL prof_toggle: viol=%0b done=%0b ncs=%0d expected viol=1 done=0 ncs=24", viol, done, ncs);
    end
    last_ncs = 5'd24;
    calc = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_fall_and_change();
    @(negedge clk);
    freq = 32'd50_000_000; prof = 1'b0; calc = 1'b1;
    repeat (5) @(negedge clk);
    freq = 32'd51_000_000; calc = 1'b0;
    @(negedge clk);
    checks++;
    if (viol !== 1'b1 || done !== 1'b0) begin
      errors++;
      $display("FAIL fall_and_change: viol=%0b done=%0b expected viol=1 done=0", viol, done);
    end
  endtask

  task automatic test_drop_mid_high();
    @(negedge clk);
    freq = 32'd50_000_000; prof = 1'b0; calc = 1'b1;
    repeat (45) @(negedge clk);
    calc = 1'b0;
    @(negedge clk);
    checks++;
    if (viol !== 1'b0 || done !== 1'b0 || ncs !== last_ncs) begin
      errors++;
      $display("FAIL drop_mid_high: viol=%0b done=%0b ncs=%0d expected viol=0 done=0 ncs=%0d", viol, done, ncs, last_ncs);
    end
    repeat (70) @(negedge clk);
    checks++;
    if (done !== 1'b0 || ncs !== last_ncs) begin
      errors++;
      $display("FAIL drop_no_result: done=%0b ncs=%0d expected done=0 ncs=%0d", done, ncs, last_ncs);
    end
  endtask

  task automatic test_reset_mid_upd();
    @(negedge clk);
    freq = 32'd50_000_000; prof = 1'b0; calc = 1'b1;
    repeat (10) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    checks++;
    if ({ncs, sat, done, viol} !== 8'd0 || {ncs6, sat6, done6, viol6} !== 9'd0) begin
      errors++;
      $display("FAIL reset_mid_upd: ncs=%0d sat=%0b done=%0b viol=%0b ncs6=%0d expected all 0", ncs, sat, done, viol, ncs6);
    end
    calc = 1'b0;
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
  endtask

  initial begin
    last_ncs = 5'd0;
    last_ncs6 = 6'd0;
    test_reset();
    run_calc(32'd50_000_000,  1'b0, 18, "p0_50M");
    run_calc(32'd10_000_000,  1'b0, 4,  "p0_10M");
    run_calc(32'd0,           1'b0, 4,  "p0_f0");
    run_calc(32'd100_000_000, 1'b0, 59, "p0_100M");
    run_calc(32'd50_000_000,  1'b1, 34, "p1_50M");
    run_calc(32'd40_000_000,  1'b1, 24, "p1_40M");
    test_lock_freq();
    test_profile_toggle_done();
    test_fall_and_change();
    test_drop_mid_high();
    run_calc(32'd100_000_000, 1'b0, 59, "p0_100M_again");
    test_reset_mid_upd();
    run_calc(32'd50_000_000,  1'b0, 18, "p0_after_reset");
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/shim_spi_cs_timing_calc.md
# shim_spi_cs_timing_calc

Parametrised successor to the fixed AD5676 n_cs-high calculator. It computes the number of SPI clock cycles n_cs must stay high between transfers, so that two conditions hold for a given SPI clock frequency: the full frame period meets the device update/conversion time, and the high time meets the device minimum. Two device timing profiles are selectable at runtime. One shared sequential ceiling divider is used, and the result saturates to the output width with a flag. It sits between the SPI clock configuration registers and the shim DAC/ADC SPI sequencers.

## Interface
- T_UPDATE_NS_0, 830: profile 0 minimum time between n_cs rising edges (ns)
- T_MIN_CS_HIGH_NS_0, 30: profile 0 minimum n_cs high time (ns)
- CMD_BITS_0, 24: profile 0 SPI frame length (bits)
- T_UPDATE_NS_1, 1000: profile 1 update/conversion time (ns)
- T_MIN_CS_HIGH_NS_1, 30: profile 1 minimum n_cs high time (ns)
- CMD_BITS_1, 16: profile 1 frame length (bits)
- MIN_CS_HIGH_CYCLES, 4: absolute floor on the result (cycles)
- OUT_WIDTH, 5: result width; saturation value is 2^OUT_WIDTH-1
- clk  in  1  system clock
- reset  in  1  synchronous, active-high reset
- spi_clk_freq_hz  in  32  SPI clock frequency (Hz)
- profile_sel  in  1  0 = profile 0, 1 = profile 1
- calc  in  1  level request; a new calculation starts on a rising edge
- n_cs_high_time  out  OUT_WIDTH  result (cycles)
- saturated  out  1  result was clipped to 2^OUT_WIDTH-1
- done  out  1  result valid; held while calc is high
- lock_viol  out  1  sticky flag: frequency or profile changed mid-calculation

## Operation
- States: IDLE, DIV_UPD, DIV_HIGH, RESULT, DONE.
- IDLE:
  - calc_d is a register of calc.
  - On calc & !calc_d, latch spi_clk_freq_hz and profile_sel, clear lock_viol and saturated, and go to DIV_UPD.
  - If calc stays high from before (for example after a violation), do not start.
- Division: ceil(T_ns·f / 1e9), computed as (T_ns·f + 999_999_999) / 1_000_000_000.
  - 64-bit dividend, 32-bit divisor, 32-bit quotient.
  - Restoring shift-subtract: shift the next dividend bit into the remainder before comparing.
  - 32 iteration cycles plus 1 finalize cycle per division.
- DIV_UPD finalize: upd = max(q − CMD_BITS, 0), computed as a signed/guarded subtract with no wrap. Load the dividend for T_MIN_CS_HIGH_NS and go to DIV_HIGH.
- DIV_HIGH finalize: hi = max(q, MIN_CS_HIGH_CYCLES). Go to RESULT.
- RESULT:
  - r = max(upd, hi).
  - If r > 2^OUT_WIDTH−1, set n_cs_high_time to all-ones and saturated to 1. Otherwise set n_cs_high_time to r[OUT_WIDTH−1:0] and saturated to 0.
  - Set done to 1 and go to DONE.
- DONE: hold the outputs. When calc goes low, clear done and go to IDLE.
- Abort checks, applied in every non-IDLE state, with the priority below:
  - First, spi_clk_freq_hz or profile_sel differs from its latched value: set lock_viol to 1, clear done, go to IDLE. n_cs_high_time keeps its previous value.
  - Else, calc is low: clear done and go to IDLE with no flag.
- lock_viol stays set until reset or the next accepted calc rising edge.
- f = 0 gives both quotients 0, so the result is MIN_CS_HIGH_CYCLES.
- Any state encoding not listed above goes to IDLE.

## Timing
- Reset values:
  - n_cs_high_time = 0, saturated = 0, done = 0, lock_viol = 0
  - state = IDLE, calc_d = 0
  - all datapath registers = 0
- If calc is sampled rising at edge k:
  - DIV_UPD covers edges k+1..k+33.
  - DIV_HIGH covers edges k+34..k+66.
  - RESULT is edge k+67, so done and n_cs_high_time are visible after edge k+67.
  - Fixed latency is 67 cycles, independent of operands.
- Abort: lock_viol rises, and done falls, on the edge that samples the mismatch.
- Both calc falling and a frequency change in the same cycle: lock_viol wins.
- Reset mid-calculation returns to IDLE at the next edge, with all outputs at their reset values.
- Overflow bound: T_ns ≤ 2^31 so that T_ns·f + 999_999_999 fits in 64 bits. Quotients above 2^32−1 are out of scope.

## Test plan
- Profile 0, f = 50_000_000, calc rising:
  - upd = 42−24 = 18, hi = max(2, 4) = 4.
  - Expected: n_cs_high_time = 18, saturated = 0, done exactly 67 cycles after the sampled edge.
- Profile 0, f = 10_000_000:
  - upd = max(9−24, 0) = 0, hi = 4.
  - Expected: result 4. Also f = 0 gives result 4.
- Profile 0, f = 100_000_000:
  - 83−24 = 59 > 31.
  - Expected: n_cs_high_time = 31, saturated = 1.
- Profile 1, f = 50_000_000:
  - upd = 50−16 = 34.
  - Expected: OUT_WIDTH=5 gives 31 with saturated = 1; with OUT_WIDTH=6 overridden, result 34 with saturated = 0.
- Change spi_clk_freq_hz at cycle 20, and separately toggle profile_sel in DONE:
  - Expected: lock_viol = 1 and done = 0 on that edge, n_cs_high_time unchanged, no restart while calc stays high.
  - Drop and re-raise calc: lock_viol clears and a new result follows 67 cycles later.
- calc dropped mid-DIV_HIGH, then reset asserted mid-DIV_UPD:
  - Expected: return to IDLE with no flag; reset clears all outputs to 0 on the next edge.
